// File: rtl/madd_msub_host_if.sv
// Host front-end for the serial modular add/sub engine: load P/A/B, start, unload result.
// Define MMD_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles (pulses err).
module madd_msub_host_if #(
    parameter int WORDS   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic        err,
    output logic [15:0] eng_datain,
    output logic        eng_loada,
    output logic        eng_loadb,
    output logic        eng_loadp,
    output logic        eng_madd_en,
    output logic        eng_msub_en,
    output logic        eng_outs0,
    output logic        eng_outs1,
    input  logic [15:0] eng_regs0out,
    input  logic [15:0] eng_regs1out,
    input  logic        eng_result_rdy,
    input  logic        eng_result_flag
);

    localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_P,
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        UNLOAD
    } state_t;

    state_t         state;
    logic [WCW-1:0] wcnt;
    logic           op_q;
    logic           flag_q;

    logic loading;
    logic in_beat;
    logic out_beat;
    logic wlast;
    logic timeout;

    // Strobes are gated by rst so a reset cycle never disturbs the engine.
    assign loading = !rst && (state == LOAD_P || state == LOAD_A || state == LOAD_B);
    assign in_ready = loading;
    assign in_beat = loading && in_valid;

    assign out_valid = !rst && (state == UNLOAD);
    assign out_beat = out_valid && out_ready;
    assign out_data = flag_q ? eng_regs1out : eng_regs0out;

    assign cmd_ready = (state == IDLE);
    assign busy = (state != IDLE);
    assign wlast = (wcnt == WLAST);

    assign eng_datain = in_data;
    assign eng_loadp = in_beat && (state == LOAD_P);
    assign eng_loada = in_beat && (state == LOAD_A);
    assign eng_loadb = in_beat && (state == LOAD_B);
    assign eng_madd_en = !rst && (state == START) && !op_q;
    assign eng_msub_en = !rst && (state == START) && op_q;
    assign eng_outs0 = out_beat && !flag_q;
    assign eng_outs1 = out_beat && flag_q;

`ifdef MMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign timeout = !rst && (state == WAIT) && !eng_result_rdy
                     && (tcnt == TW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout = 1'b0;
`endif

    assign err = timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wcnt   <= '0;
            op_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        wcnt  <= '0;
                        state <= LOAD_P;
                    end
                end
                LOAD_P: begin
                    if (in_beat) begin
                        wcnt <= wlast ? '0 : wcnt + 1'b1;
                        if (wlast) state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (in_beat) begin
                        wcnt <= wlast ? '0 : wcnt + 1'b1;
                        if (wlast) state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_beat) begin
                        wcnt <= wlast ? '0 : wcnt + 1'b1;
                        if (wlast) state <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_result_rdy) begin
                        flag_q <= eng_result_flag;
                        wcnt   <= '0;
                        state  <= UNLOAD;
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
                UNLOAD: begin
                    if (out_beat) begin
                        wcnt <= wcnt + 1'b1;
                        if (wlast) state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_madd_msub_host_if.sv
// Bench for madd_msub_host_if: vector table, hand sequences, random ops on a behavioural engine.
// Build with MMD_TIMEOUT_EN defined to cover the WAIT abort path.
module tb_madd_msub_host_if;

    localparam int W   = 16;
    localparam int NB  = 16 * W;
    localparam int TMO = 8;

    typedef logic [NB-1:0] wide_t;

    typedef struct {
        logic        op;
        logic [15:0] p0;
        logic [15:0] a0;
        logic [15:0] b0;
        logic        flag;
        int          lat;
        int          bub_a;
        int          bp;
        int          hold;
        logic [15:0] exp0;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        busy, err;
    logic [15:0] eng_datain;
    logic        eng_loada, eng_loadb, eng_loadp;
    logic        eng_madd_en, eng_msub_en, eng_outs0, eng_outs1;
    logic [15:0] eng_regs0out, eng_regs1out;
    logic        eng_result_rdy, eng_result_flag;

    always #5 clk = ~clk;

    madd_msub_host_if #(.WORDS(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err),
        .eng_datain(eng_datain),
        .eng_loada(eng_loada), .eng_loadb(eng_loadb), .eng_loadp(eng_loadp),
        .eng_madd_en(eng_madd_en), .eng_msub_en(eng_msub_en),
        .eng_outs0(eng_outs0), .eng_outs1(eng_outs1),
        .eng_regs0out(eng_regs0out), .eng_regs1out(eng_regs1out),
        .eng_result_rdy(eng_result_rdy), .eng_result_flag(eng_result_flag)
    );

    // Reference arithmetic: (A+B) mod P or (A-B) mod P for A,B < P.
    function automatic wide_t mod_op(input logic sub, input wide_t p, input wide_t a,
                                     input wide_t b);
        logic [NB:0] s;
        if (sub) begin
            if (a >= b) s = {1'b0, a} - {1'b0, b};
            else s = {1'b0, a} + {1'b0, p} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, p}) s = s - {1'b0, p};
        end
        return s[NB-1:0];
    endfunction

    function automatic wide_t rnd_wide();
        wide_t r;
        for (int i = 0; i < NB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural engine: shift-in loads, latency countdown, rotating result registers.
    wide_t e_p, e_a, e_b, e_r0, e_r1;
    logic  e_sub;
    logic  e_rdy;
    logic  e_flag = 1'b0;
    int    e_lat = 1;
    int    e_cnt;

    assign eng_regs0out = e_r0[15:0];
    assign eng_regs1out = e_r1[15:0];
    assign eng_result_rdy = e_rdy;
    assign eng_result_flag = e_flag;

    always @(posedge clk) begin
        if (rst) begin
            e_rdy <= 1'b0;
            e_cnt <= 0;
        end else begin
            if (eng_loadp) e_p <= {eng_datain, e_p[NB-1:16]};
            if (eng_loada) e_a <= {eng_datain, e_a[NB-1:16]};
            if (eng_loadb) e_b <= {eng_datain, e_b[NB-1:16]};
            if (eng_madd_en || eng_msub_en) begin
                e_rdy <= 1'b0;
                e_cnt <= e_lat;
                e_sub <= eng_msub_en;
            end else if (e_cnt != 0) begin
                e_cnt <= e_cnt - 1;
                if (e_cnt == 1) begin
                    e_rdy <= 1'b1;
                    e_r0 <= e_flag ? ~mod_op(e_sub, e_p, e_a, e_b) : mod_op(e_sub, e_p, e_a, e_b);
                    e_r1 <= e_flag ? mod_op(e_sub, e_p, e_a, e_b) : ~mod_op(e_sub, e_p, e_a, e_b);
                end
            end
            if (eng_outs0) e_r0 <= {e_r0[15:0], e_r0[NB-1:16]};
            if (eng_outs1) e_r1 <= {e_r1[15:0], e_r1[NB-1:16]};
        end
    end

    // Monitor: strobe counts and protocol rule violations, sampled mid-cycle.
    int          cyc = 0;
    int          n_lp, n_la, n_lb, n_madd, n_msub, n_osel, n_ooth, n_err, n_ov, viol;
    int          first_lp, start_cyc, err_cyc;
    logic        pend_hold;
    logic [15:0] hold_data;

    always @(negedge clk) begin
        cyc++;
        if ($countones({eng_loadp, eng_loada, eng_loadb, eng_madd_en, eng_msub_en,
                        eng_outs0, eng_outs1}) > 1) viol++;
        if ((eng_loadp || eng_loada || eng_loadb) && !(in_valid && in_ready)) viol++;
        if ((eng_outs0 || eng_outs1) && !(out_valid && out_ready)) viol++;
        if (cmd_ready == busy) viol++;
        if (eng_loada && n_lp != W) viol++;
        if (eng_loadb && n_la != W) viol++;
        if ((eng_madd_en || eng_msub_en) && n_lb != W) viol++;
        if (pend_hold && out_valid && out_data != hold_data) viol++;
        pend_hold = out_valid && !out_ready;
        hold_data = out_data;
        if (eng_loadp) begin
            if (n_lp == 0) first_lp = cyc;
            n_lp++;
        end
        if (eng_loada) n_la++;
        if (eng_loadb) n_lb++;
        if (eng_madd_en) begin n_madd++; start_cyc = cyc; end
        if (eng_msub_en) begin n_msub++; start_cyc = cyc; end
        if (eng_outs0) begin if (e_flag) n_ooth++; else n_osel++; end
        if (eng_outs1) begin if (e_flag) n_osel++; else n_ooth++; end
        if (err) begin
            if (n_err == 0) err_cyc = cyc;
            n_err++;
        end
        if (out_valid) n_ov++;
    end

    int n_chk = 0;
    int n_pass = 0;
    int n_hto = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic check_w(input string name, input wide_t got, input wide_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic clear_counts();
        n_lp = 0; n_la = 0; n_lb = 0; n_madd = 0; n_msub = 0;
        n_osel = 0; n_ooth = 0; n_err = 0; n_ov = 0; viol = 0;
        first_lp = -1; start_cyc = -1; err_cyc = -1; pend_hold = 1'b0;
    endtask

    task automatic start_cmd(input logic op, input int hold);
        int t;
        t = 0;
        cmd_op = op;
        cmd_valid = 1'b1;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 100);
        if (!cmd_ready) n_hto++;
        @(posedge clk); #1;
        if (hold != 0) cmd_op = ~op;
        else cmd_valid = 1'b0;
    endtask

    task automatic send_words(input wide_t v, input int bub, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            if (n_hto != 0) break;
            if (i > 0 && (bub == 1 || (bub == 2 && $urandom_range(0, 2) == 0))) begin
                in_valid = 1'b0;
                in_data = 16'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data = v[i*16 +: 16];
            t = 0;
            do begin @(negedge clk); t++; end while (!in_ready && t < 100);
            if (!in_ready) n_hto++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic op, input wide_t p, input wide_t a, input wide_t b,
                         input int bub_o, input int bub_a, input int hold);
        start_cmd(op, hold);
        send_words(p, bub_o, W);
        send_words(a, bub_a, W);
        send_words(b, bub_o, W);
        cmd_valid = 1'b0;
    endtask

    task automatic unload(input int bp, output wide_t res, output int k);
        int t, ph;
        t = 0; ph = 0; k = 0; res = '0;
        while (k < W && t < 400 && n_hto == 0) begin
            case (bp)
                0: out_ready = 1'b1;
                1: out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            t++; ph++;
            if (out_valid && out_ready) begin
                res[k*16 +: 16] = out_data;
                k++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        if (k < W) n_hto++;
    endtask

    task automatic finish_op(input string tag, input logic op, input wide_t exp,
                             input wide_t res, input int k, input bit zb);
        check({tag, "_beats"}, k, W);
        check_w({tag, "_result"}, res, exp);
        check({tag, "_loadp"}, n_lp, W);
        check({tag, "_loada"}, n_la, W);
        check({tag, "_loadb"}, n_lb, W);
        check({tag, "_madd"}, n_madd, op ? 0 : 1);
        check({tag, "_msub"}, n_msub, op ? 1 : 0);
        check({tag, "_rot_sel"}, n_osel, W);
        check({tag, "_rot_other"}, n_ooth, 0);
        check({tag, "_protocol"}, viol, 0);
        check({tag, "_err"}, n_err, 0);
        check({tag, "_busy_after"}, int'(busy), 0);
        if (zb) check({tag, "_load_latency"}, start_cyc - first_lp, 3 * W);
    endtask

    vec_t  vecs[7];
    vec_t  v;
    wide_t p, a, b, res;
    int    k;
    logic  op;
    string tag;

    initial begin
        //          op    p0       a0       b0       flg   lat bub bp hold exp0
        vecs[0] = '{1'b0, 16'hFFF1, 16'h0005, 16'h0007, 1'b0, 3,  0, 0, 0, 16'h000C};
        vecs[1] = '{1'b1, 16'hFFF1, 16'h0003, 16'h0005, 1'b1, 3,  0, 0, 0, 16'hFFEF};
        vecs[2] = '{1'b0, 16'hFFF1, 16'hFFF0, 16'h0005, 1'b0, 40, 0, 0, 0, 16'h0004};
        vecs[3] = '{1'b1, 16'hFFF1, 16'h0007, 16'h0007, 1'b1, 1,  0, 1, 0, 16'h0000};
        vecs[4] = '{1'b0, 16'h8001, 16'h0001, 16'h0002, 1'b1, 5,  0, 1, 1, 16'h0003};
        vecs[5] = '{1'b1, 16'h00FF, 16'h000A, 16'h0003, 1'b0, 2,  1, 0, 0, 16'h0007};
        vecs[6] = '{1'b1, 16'h1000, 16'h0000, 16'h0001, 1'b0, 2,  1, 1, 0, 16'h0FFF};

        cmd_valid = 1'b0; cmd_op = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_err", int'(err), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            tag = $sformatf("v%0d", i);
            p = wide_t'(v.p0); a = wide_t'(v.a0); b = wide_t'(v.b0);
            clear_counts();
            e_flag = v.flag;
            e_lat = v.lat;
            issue(v.op, p, a, b, 0, v.bub_a, v.hold);
            unload(v.bp, res, k);
            finish_op(tag, v.op, mod_op(v.op, p, a, b), res, k, v.bub_a == 0);
            check_w({tag, "_word0"}, wide_t'(res[15:0]), wide_t'(v.exp0));
            check_w({tag, "_upper"}, wide_t'(res[NB-1:16]), '0);
        end

        // Reset during LOAD_B after five beats, with a word still offered.
        clear_counts();
        e_lat = 3;
        start_cmd(1'b0, 0);
        send_words(wide_t'(16'hFFF1), 0, W);
        send_words(wide_t'(16'h0005), 0, W);
        send_words(wide_t'(16'h0007), 0, 5);
        in_valid = 1'b1;
        in_data = 16'h1234;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_strobes", int'({eng_loadp, eng_loada, eng_loadb}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_strobes", int'({eng_loadp, eng_loada, eng_loadb, eng_madd_en,
                                   eng_msub_en, eng_outs0, eng_outs1}), 0);
        check("rst_partial_b", n_lb, 5);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Engine that never answers.
        clear_counts();
        e_lat = 0;
        e_flag = 1'b0;
        issue(1'b1, wide_t'(16'h00F1), wide_t'(16'h0003), wide_t'(16'h0004), 0, 0, 0);
        out_ready = 1'b1;
        repeat (30) @(negedge clk);
`ifdef MMD_TIMEOUT_EN
        check("tmo_err_pulses", n_err, 1);
        check("tmo_err_cycle", err_cyc - start_cyc, TMO);
        check("tmo_idle", int'(busy), 0);
        check("tmo_no_unload", n_ov, 0);
`else
        check("wait_no_err", n_err, 0);
        check("wait_held", int'(busy), 1);
        check("wait_no_unload", n_ov, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        out_ready = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            p = rnd_wide();
            p[NB-1] = 1'b1;
            a = rnd_wide();
            if (a >= p) a = a - p;
            b = rnd_wide();
            if (b >= p) b = b - p;
            op = 1'($urandom_range(0, 1));
            e_flag = 1'($urandom_range(0, 1));
            e_lat = $urandom_range(1, 20);
            clear_counts();
            issue(op, p, a, b, 2, 2, $urandom_range(0, 1));
            unload(2, res, k);
            finish_op($sformatf("r%0d", i), op, mod_op(op, p, a, b), res, k, 1'b0);
        end

        check("handshake_timeouts", n_hto, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/madd_msub_host_if.md
Name: madd_msub_host_if

Overview:
- Host-side driver for the serial modular add/subtract engine.
- Accepts a command plus a word stream of modulus P, operand A and operand B over valid/ready handshakes.
- Streams those words into the engine's load strobes, pulses the engine start, and waits for result_rdy.
- Reads the selected result register back out word by word to the host over a valid/ready output stream.

Parameters:
- WORDS, 16, 16-bit words per operand; LS word first on every stream.
- TIMEOUT, 1024, maximum WAIT cycles before abort (used only with MMD_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  high in IDLE only.
- cmd_op  input  1  0 = modular add, 1 = modular subtract.
- in_valid  input  1  operand word valid.
- in_ready  output  1  high in LOAD_P, LOAD_A and LOAD_B.
- in_data  input  16  operand word.
- out_valid  output  1  result word valid.
- out_ready  input  1  host accepts result word.
- out_data  output  16  result word.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  one-cycle abort pulse.
- eng_datain  output  16  word to engine; equals in_data.
- eng_loada, eng_loadb, eng_loadp  output  1 each  engine load strobes.
- eng_madd_en, eng_msub_en  output  1 each  engine start pulses.
- eng_outs0, eng_outs1  output  1 each  engine result-register rotate strobes.
- eng_regs0out, eng_regs1out  input  16 each  engine result-register current words.
- eng_result_rdy  input  1  engine done.
- eng_result_flag  input  1  selects the valid result register (0 = regs0, 1 = regs1).

Behaviour:
- States: IDLE, LOAD_P, LOAD_A, LOAD_B, START, WAIT, UNLOAD.
- Word counter wcnt runs 0..WORDS-1; op_q and flag_q are internal registers.
- Reset: state IDLE, wcnt=0, op_q=0, flag_q=0; all strobes, out_valid, busy and err are 0. Reset in any state, mid-operation included, returns to IDLE with no further strobes. Any partially loaded engine contents are abandoned.
- IDLE: cmd_ready=1. On cmd_valid, latch op_q=cmd_op, clear wcnt, go to LOAD_P. in_valid is ignored in IDLE.
- LOAD_P, LOAD_A, LOAD_B:
  - in_ready=1. On a beat (in_valid&in_ready), the matching eng_loadX=1 that same cycle (combinational) and wcnt increments.
  - No beat means no strobe; bubbles are legal and the engine holds.
  - Beat with wcnt=WORDS-1: clear wcnt, advance P->A->B->START.
- START: exactly one cycle. eng_madd_en=1 if op_q=0, else eng_msub_en=1. Go to WAIT.
- WAIT: no strobes. When eng_result_rdy=1, latch flag_q=eng_result_flag, clear wcnt, go to UNLOAD.
- UNLOAD:
  - out_valid=1; out_data = flag_q ? eng_regs1out : eng_regs0out (combinational).
  - On out_valid&out_ready: pulse eng_outs1 if flag_q=1, else eng_outs0, to rotate the next word into view, and increment wcnt.
  - When out_ready=0, no strobe and out_data holds.
  - Beat with wcnt=WORDS-1: go to IDLE.
- Latency, zero-bubble host: 3*WORDS load cycles + 1 START cycle + engine time + WORDS unload cycles.
- cmd_valid outside IDLE is ignored; cmd_ready=0.
- At most one of eng_loada/b/p, eng_madd_en/msub_en, eng_outs0/outs1 is high in any cycle.

Optional Feature:
- Macro MMD_TIMEOUT_EN.
- Defined: a WAIT-cycle counter resets on entry to WAIT. If it reaches TIMEOUT without eng_result_rdy, pulse err=1 for one cycle and go to IDLE; no unload occurs.
- Undefined: WAIT is unbounded and err is tied to 0.

Test Plan:
- Add: WORDS=16, P=0xFFF1 in word 0 with remaining words 0, A=5, B=7, cmd_op=0 -> exactly 16 eng_loadp, then 16 eng_loada, then 16 eng_loadb; one eng_madd_en pulse; on result_rdy, 16 output beats with word 0 = 0x000C and the rest 0.
- Sub wrap: A=3, B=5, P=0xFFF1 (LS word), cmd_op=1 -> one eng_msub_en pulse; output word 0 = 0xFFEF; the rotate strobe pulses on the register selected by eng_result_flag.
- Backpressure: out_ready toggling 1,0,0,1 -> no eng_outsX while out_ready=0; out_data stable; exactly 16 beats delivered.
- Input bubbles: in_valid low every other cycle during LOAD_A -> load strobes only on beats; LOAD_B entered after the 16th A beat.
- Reset in LOAD_B after 5 beats -> next cycle state IDLE, cmd_ready=1, busy=0, all strobes 0.
- MMD_TIMEOUT_EN with TIMEOUT=8 and eng_result_rdy held 0 -> err pulses exactly at WAIT cycle 8, then IDLE with no out_valid.
